axil_kg_regfile_mc: RTL and testbench

Parametrised multi-channel AXI4-Lite register file for the kugelblitz datapath.
- Per channel: a software-written address/data pair is launched as one valid/ready transaction toward kugelblitz logic.
- Adds backpressure, busy status, auto-increment, soft flush and a transfer counter.
- Sits between the AXI-Lite interconnect and N kugelblitz command consumers.

---
 rtl/axil_kg_regfile_mc.sv | 200 ++++++++++++++++++++
 tb/tb_axil_kg_regfile_mc.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_kg_regfile_mc.sv
// Multi-channel AXI4-Lite register file that launches ADDR/DATA command pairs to kugelblitz consumers.
// Optional macro KG_REGFILE_ERR_EN: SLVERR on unmapped or dropped accesses, plus sticky STATUS.overflow.
module axil_kg_regfile_mc #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 16,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int CHANNELS   = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic [ADDR_WIDTH-1:0]          s_axil_awaddr,
   input  logic [2:0]                     s_axil_awprot,
   input  logic                           s_axil_awvalid,
   output logic                           s_axil_awready,
   input  logic [DATA_WIDTH-1:0]          s_axil_wdata,
   input  logic [STRB_WIDTH-1:0]          s_axil_wstrb,
   input  logic                           s_axil_wvalid,
   output logic                           s_axil_wready,
   output logic [1:0]                     s_axil_bresp,
   output logic                           s_axil_bvalid,
   input  logic                           s_axil_bready,
   input  logic [ADDR_WIDTH-1:0]          s_axil_araddr,
   input  logic [2:0]                     s_axil_arprot,
   input  logic                           s_axil_arvalid,
   output logic                           s_axil_arready,
   output logic [DATA_WIDTH-1:0]          s_axil_rdata,
   output logic [1:0]                     s_axil_rresp,
   output logic                           s_axil_rvalid,
   input  logic                           s_axil_rready,
   output logic [CHANNELS*DATA_WIDTH-1:0] m_kg_addr,
   output logic [CHANNELS*DATA_WIDTH-1:0] m_kg_data,
   output logic [CHANNELS-1:0]            m_kg_valid,
   input  logic [CHANNELS-1:0]            m_kg_ready
);
   localparam int CW = ADDR_WIDTH - 4;
   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   logic [DATA_WIDTH-1:0] addr_q  [CHANNELS];
   logic [DATA_WIDTH-1:0] data_q  [CHANNELS];
   logic [15:0]           count_q [CHANNELS];
   logic [CHANNELS-1:0]   valid_q, auto_inc_q, ovf_q;

   logic                  aw_hs, ar_hs, w_mapped, r_mapped, w_err, r_err;
   logic [CW-1:0]         w_ch, r_ch;
   logic [1:0]            w_reg, r_reg;
   logic [CHANNELS-1:0]   sel, busy_eff, done, wr_addr, launch, drop, wr_ctrl, flush;
   logic [DATA_WIDTH-1:0] rd_word;
   logic                  unused_bits;

   function automatic logic [DATA_WIDTH-1:0] merge(input logic [DATA_WIDTH-1:0] cur,
                                                   input logic [DATA_WIDTH-1:0] nxt,
                                                   input logic [STRB_WIDTH-1:0] strb);
      logic [DATA_WIDTH-1:0] res;
      res = cur;
      for (int b = 0; b < STRB_WIDTH; b++)
         if (strb[b]) res[b*8 +: 8] = nxt[b*8 +: 8];
      return res;
   endfunction

   assign w_ch     = s_axil_awaddr[ADDR_WIDTH-1:4];
   assign w_reg    = s_axil_awaddr[3:2];
   assign r_ch     = s_axil_araddr[ADDR_WIDTH-1:4];
   assign r_reg    = s_axil_araddr[3:2];
   assign w_mapped = w_ch < CW'(CHANNELS);
   assign r_mapped = r_ch < CW'(CHANNELS);

   assign aw_hs          = s_axil_awvalid & s_axil_wvalid & ~s_axil_bvalid;
   assign ar_hs          = s_axil_arvalid & ~s_axil_rvalid;
   assign s_axil_awready = aw_hs & rst_n;
   assign s_axil_wready  = aw_hs & rst_n;
   assign s_axil_arready = ~s_axil_rvalid & rst_n;

   // A consumer accepting this cycle frees the channel, so a same-cycle write relaunches.
   always_comb begin
      sel      = '0;
      busy_eff = '0;
      done     = '0;
      wr_addr  = '0;
      launch   = '0;
      drop     = '0;
      wr_ctrl  = '0;
      flush    = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         sel[c]      = aw_hs && (w_ch == CW'(c));
         busy_eff[c] = valid_q[c] & ~m_kg_ready[c];
         done[c]     = valid_q[c] & m_kg_ready[c];
         wr_addr[c]  = sel[c] && (w_reg == 2'd0) && !busy_eff[c];
         launch[c]   = sel[c] && (w_reg == 2'd1) && !busy_eff[c];
         drop[c]     = sel[c] && !w_reg[1] && busy_eff[c];
         wr_ctrl[c]  = sel[c] && (w_reg == 2'd3);
         flush[c]    = wr_ctrl[c] && s_axil_wstrb[0] && s_axil_wdata[1];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < CHANNELS; c++) begin
            addr_q[c]  <= '0;
            data_q[c]  <= '0;
            count_q[c] <= '0;
         end
         valid_q    <= '0;
         auto_inc_q <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (wr_addr[c])
               addr_q[c] <= merge(addr_q[c], s_axil_wdata, s_axil_wstrb);
            else if (done[c] && auto_inc_q[c])
               addr_q[c] <= addr_q[c] + DATA_WIDTH'(4);
            if (launch[c])
               data_q[c] <= merge(data_q[c], s_axil_wdata, s_axil_wstrb);
            if (launch[c])
               valid_q[c] <= 1'b1;
            else if (flush[c] || done[c])
               valid_q[c] <= 1'b0;
            if (done[c])
               count_q[c] <= count_q[c] + 16'd1;
            if (wr_ctrl[c] && s_axil_wstrb[0])
               auto_inc_q[c] <= s_axil_wdata[0];
         end
      end
   end

`ifdef KG_REGFILE_ERR_EN
   assign w_err = !w_mapped || (|drop);
   assign r_err = !r_mapped;
   assign unused_bits = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[1:0], s_axil_araddr[1:0]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= '0;
      end else begin
         for (int c = 0; c < CHANNELS; c++) begin
            if (drop[c])
               ovf_q[c] <= 1'b1;
            else if (sel[c] && (w_reg == 2'd2) && s_axil_wstrb[0] && s_axil_wdata[1])
               ovf_q[c] <= 1'b0;
         end
      end
   end
`else
   assign w_err = 1'b0;
   assign r_err = 1'b0;
   assign ovf_q = '0;
   assign unused_bits = ^{s_axil_awprot, s_axil_arprot, s_axil_awaddr[1:0], s_axil_araddr[1:0],
                          w_mapped, r_mapped, drop};
`endif

   always_comb begin
      rd_word = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         if (r_ch == CW'(c)) begin
            case (r_reg)
               2'd0:    rd_word = addr_q[c];
               2'd1:    rd_word = data_q[c];
               2'd2:    rd_word = {count_q[c], 14'd0, ovf_q[c], valid_q[c]};
               default: rd_word = {31'd0, auto_inc_q[c]};
            endcase
         end
      end
   end

   // Read data is captured from pre-edge state, so a colliding write is not visible yet.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_axil_bvalid <= 1'b0;
         s_axil_bresp  <= OKAY;
         s_axil_rvalid <= 1'b0;
         s_axil_rdata  <= '0;
         s_axil_rresp  <= OKAY;
      end else begin
         if (aw_hs) begin
            s_axil_bvalid <= 1'b1;
            s_axil_bresp  <= w_err ? SLVERR : OKAY;
         end else if (s_axil_bready) begin
            s_axil_bvalid <= 1'b0;
         end
         if (ar_hs) begin
            s_axil_rvalid <= 1'b1;
            s_axil_rdata  <= rd_word;
            s_axil_rresp  <= r_err ? SLVERR : OKAY;
         end else if (s_axil_rready) begin
            s_axil_rvalid <= 1'b0;
         end
      end
   end

   always_comb begin
      m_kg_addr = '0;
      m_kg_data = '0;
      for (int c = 0; c < CHANNELS; c++) begin
         m_kg_addr[c*DATA_WIDTH +: DATA_WIDTH] = addr_q[c];
         m_kg_data[c*DATA_WIDTH +: DATA_WIDTH] = data_q[c];
      end
   end

   assign m_kg_valid = valid_q;

endmodule

// File: tb/tb_axil_kg_regfile_mc.sv
// Self-checking bench for axil_kg_regfile_mc: vector table plus scoreboarded AXI responses.
module tb_axil_kg_regfile_mc;
   localparam int CH = 4;
   localparam logic [1:0] OKAY = 2'b00;
`ifdef KG_REGFILE_ERR_EN
   localparam logic [1:0]  ERR_UNMAP = 2'b10;
   localparam logic [1:0]  ERR_DROP  = 2'b10;
   localparam logic [31:0] OVF_BIT   = 32'h2;
`else
   localparam logic [1:0]  ERR_UNMAP = 2'b00;
   localparam logic [1:0]  ERR_DROP  = 2'b00;
   localparam logic [31:0] OVF_BIT   = 32'h0;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b1;
   logic [15:0]     s_axil_awaddr = '0;
   logic            s_axil_awvalid = 1'b0;
   logic            s_axil_awready;
   logic [31:0]     s_axil_wdata = '0;
   logic [3:0]      s_axil_wstrb = '0;
   logic            s_axil_wvalid = 1'b0;
   logic            s_axil_wready;
   logic [1:0]      s_axil_bresp;
   logic            s_axil_bvalid;
   logic            s_axil_bready = 1'b1;
   logic [15:0]     s_axil_araddr = '0;
   logic            s_axil_arvalid = 1'b0;
   logic            s_axil_arready;
   logic [31:0]     s_axil_rdata;
   logic [1:0]      s_axil_rresp;
   logic            s_axil_rvalid;
   logic            s_axil_rready = 1'b1;
   logic [CH*32-1:0] m_kg_addr;
   logic [CH*32-1:0] m_kg_data;
   logic [CH-1:0]   m_kg_valid;
   logic [CH-1:0]   m_kg_ready = '1;

   axil_kg_regfile_mc #(.DATA_WIDTH(32), .ADDR_WIDTH(16), .CHANNELS(CH)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axil_awaddr(s_axil_awaddr), .s_axil_awprot(3'b000), .s_axil_awvalid(s_axil_awvalid),
      .s_axil_awready(s_axil_awready), .s_axil_wdata(s_axil_wdata), .s_axil_wstrb(s_axil_wstrb),
      .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready), .s_axil_bresp(s_axil_bresp),
      .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready), .s_axil_araddr(s_axil_araddr),
      .s_axil_arprot(3'b000), .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready),
      .s_axil_rdata(s_axil_rdata), .s_axil_rresp(s_axil_rresp), .s_axil_rvalid(s_axil_rvalid),
      .s_axil_rready(s_axil_rready), .m_kg_addr(m_kg_addr), .m_kg_data(m_kg_data),
      .m_kg_valid(m_kg_valid), .m_kg_ready(m_kg_ready)
   );

   always #5 clk = ~clk;

   typedef struct { string name; logic [31:0] data; logic [1:0] resp; } exp_t;
   typedef struct {
      logic        do_wr;
      logic [15:0] addr;
      logic [31:0] wdata;
      logic [3:0]  strb;
      logic [1:0]  bresp;
      logic [15:0] raddr;
      logic [31:0] rdata;
      logic [1:0]  rresp;
   } vec_t;

   exp_t rd_q[$];
   exp_t wr_q[$];
   exp_t re, we;
   vec_t vecs[11];
   int   total = 0;
   int   bad = 0;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
      end
   endtask

   function automatic logic [31:0] lane(input logic [CH*32-1:0] v, input int c);
      return v[c*32 +: 32];
   endfunction

   // Response scoreboards: expectations are queued at issue time and retired as responses appear.
   always @(negedge clk) begin
      if (rst_n && s_axil_rvalid && s_axil_rready) begin
         if (rd_q.size() == 0) begin
            checkOutput("unexpected_rvalid", 32'd1, 32'd0);
         end else begin
            re = rd_q.pop_front();
            checkOutput({re.name, "_rdata"}, s_axil_rdata, re.data);
            checkOutput({re.name, "_rresp"}, {30'd0, s_axil_rresp}, {30'd0, re.resp});
         end
      end
      if (rst_n && s_axil_bvalid && s_axil_bready) begin
         if (wr_q.size() == 0) begin
            checkOutput("unexpected_bvalid", 32'd1, 32'd0);
         end else begin
            we = wr_q.pop_front();
            checkOutput({we.name, "_bresp"}, {30'd0, s_axil_bresp}, {30'd0, we.resp});
         end
      end
   end

   task automatic axi_write(input string name, input logic [15:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp, input logic [CH-1:0] pulse);
      int n;
      @(posedge clk); #1;
      s_axil_awaddr = addr; s_axil_wdata = data; s_axil_wstrb = strb;
      s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
      m_kg_ready = m_kg_ready | pulse;
      wr_q.push_back('{name, 32'd0, exp_resp});
      n = 0;
      @(negedge clk);
      while (!s_axil_awready && n < 50) begin @(negedge clk); n++; end
      if (!s_axil_awready) checkOutput({name, "_awready"}, {31'd0, s_axil_awready}, 32'd1);
      @(posedge clk); #1;
      s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
      m_kg_ready = m_kg_ready & ~pulse;
      n = 0;
      @(negedge clk);
      while (!s_axil_bvalid && n < 50) begin @(negedge clk); n++; end
      if (!s_axil_bvalid) checkOutput({name, "_bvalid"}, {31'd0, s_axil_bvalid}, 32'd1);
   endtask

   task automatic axi_read(input string name, input logic [15:0] addr, input logic [31:0] exp_data,
                           input logic [1:0] exp_resp);
      int n;
      @(posedge clk); #1;
      s_axil_araddr = addr; s_axil_arvalid = 1'b1;
      rd_q.push_back('{name, exp_data, exp_resp});
      n = 0;
      @(negedge clk);
      while (!s_axil_arready && n < 50) begin @(negedge clk); n++; end
      if (!s_axil_arready) checkOutput({name, "_arready"}, {31'd0, s_axil_arready}, 32'd1);
      @(posedge clk); #1;
      s_axil_arvalid = 1'b0;
      n = 0;
      @(negedge clk);
      while (!s_axil_rvalid && n < 50) begin @(negedge clk); n++; end
      if (!s_axil_rvalid) checkOutput({name, "_rvalid"}, {31'd0, s_axil_rvalid}, 32'd1);
   endtask

   // Write and read issued in the same cycle; both handshake on the same edge.
   task automatic axi_concurrent(input string name, input logic [15:0] waddr, input logic [31:0] wdata,
                                 input logic [1:0] bresp, input logic [15:0] raddr,
                                 input logic [31:0] rdata, input logic [1:0] rresp);
      @(posedge clk); #1;
      s_axil_awaddr = waddr; s_axil_wdata = wdata; s_axil_wstrb = 4'hF;
      s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
      s_axil_araddr = raddr; s_axil_arvalid = 1'b1;
      wr_q.push_back('{name, 32'd0, bresp});
      rd_q.push_back('{name, rdata, rresp});
      @(negedge clk);
      checkOutput({name, "_awready"}, {31'd0, s_axil_awready}, 32'd1);
      checkOutput({name, "_arready"}, {31'd0, s_axil_arready}, 32'd1);
      @(posedge clk); #1;
      s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0; s_axil_arvalid = 1'b0;
      @(negedge clk);
      checkOutput({name, "_bvalid"}, {31'd0, s_axil_bvalid}, 32'd1);
      checkOutput({name, "_rvalid"}, {31'd0, s_axil_rvalid}, 32'd1);
   endtask

   task automatic applyStimulus(input vec_t v, input int idx);
      string nm;
      nm = $sformatf("vec%0d", idx);
      if (v.do_wr) axi_write(nm, v.addr, v.wdata, v.strb, v.bresp, '0);
      axi_read(nm, v.raddr, v.rdata, v.rresp);
   endtask

   task automatic pulse_ready(input int c);
      @(posedge clk); #1 m_kg_ready[c] = 1'b1;
      @(posedge clk); #1 m_kg_ready[c] = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vecs[0]  = '{1'b1, 16'h0000, 32'h12345678, 4'hF, OKAY,      16'h0000, 32'h12345678, OKAY};
      vecs[1]  = '{1'b1, 16'h0000, 32'hAABBCCDD, 4'h5, OKAY,      16'h0000, 32'h12BB56DD, OKAY};
      vecs[2]  = '{1'b1, 16'h0010, 32'hFFFFFFFF, 4'h8, OKAY,      16'h0010, 32'hFF000000, OKAY};
      vecs[3]  = '{1'b1, 16'h0034, 32'h0BADBEEF, 4'hF, OKAY,      16'h0034, 32'h0BADBEEF, OKAY};
      vecs[4]  = '{1'b0, 16'h0000, 32'h00000000, 4'h0, OKAY,      16'h0038, 32'h00010000, OKAY};
      vecs[5]  = '{1'b1, 16'h002C, 32'h00000003, 4'hF, OKAY,      16'h002C, 32'h00000001, OKAY};
      vecs[6]  = '{1'b1, 16'h002C, 32'h00000000, 4'h0, OKAY,      16'h002C, 32'h00000001, OKAY};
      vecs[7]  = '{1'b1, 16'h002C, 32'h00000000, 4'hF, OKAY,      16'h002C, 32'h00000000, OKAY};
      vecs[8]  = '{1'b1, 16'h0040, 32'hDEADBEEF, 4'hF, ERR_UNMAP, 16'h0040, 32'h00000000, ERR_UNMAP};
      vecs[9]  = '{1'b1, 16'h0018, 32'hFFFFFFFF, 4'hF, OKAY,      16'h0018, 32'h00000000, OKAY};
      vecs[10] = '{1'b0, 16'h0000, 32'h00000000, 4'h0, OKAY,      16'hFFFC, 32'h00000000, ERR_UNMAP};

      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst0_valid", {28'd0, m_kg_valid}, 32'd0);
      checkOutput("rst0_bvalid", {31'd0, s_axil_bvalid}, 32'd0);
      checkOutput("rst0_rvalid", {31'd0, s_axil_rvalid}, 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      for (int c = 0; c < CH; c++)
         axi_read($sformatf("rst0_status%0d", c), 16'(c * 16 + 8), 32'h0, OKAY);

      for (int i = 0; i < 11; i++) applyStimulus(vecs[i], i);

      // Channel 1: launch held off by backpressure, then one completing handshake.
      m_kg_ready = '0;
      axi_write("ch1_addr", 16'h0010, 32'h00001000, 4'hF, OKAY, '0);
      axi_write("ch1_data", 16'h0014, 32'hCAFEF00D, 4'hF, OKAY, '0);
      checkOutput("ch1_valid", {31'd0, m_kg_valid[1]}, 32'd1);
      repeat (3) @(negedge clk);
      checkOutput("ch1_addr_out", lane(m_kg_addr, 1), 32'h00001000);
      checkOutput("ch1_data_out", lane(m_kg_data, 1), 32'hCAFEF00D);
      axi_read("ch1_busy", 16'h0018, 32'h00000001, OKAY);
      pulse_ready(1);
      checkOutput("ch1_valid_clr", {31'd0, m_kg_valid[1]}, 32'd0);
      axi_read("ch1_done", 16'h0018, 32'h00010000, OKAY);

      // Channel 0: auto-increment wraps the address across two transfers.
      m_kg_ready[0] = 1'b1;
      axi_write("ch0_ctrl", 16'h000C, 32'h00000001, 4'hF, OKAY, '0);
      axi_write("ch0_addr", 16'h0000, 32'hFFFFFFFC, 4'hF, OKAY, '0);
      axi_write("ch0_data1", 16'h0004, 32'h00000001, 4'hF, OKAY, '0);
      checkOutput("ch0_xfer1_addr", lane(m_kg_addr, 0), 32'hFFFFFFFC);
      @(negedge clk);
      checkOutput("ch0_valid_clr", {31'd0, m_kg_valid[0]}, 32'd0);
      axi_write("ch0_data2", 16'h0004, 32'h00000002, 4'hF, OKAY, '0);
      checkOutput("ch0_xfer2_valid", {31'd0, m_kg_valid[0]}, 32'd1);
      checkOutput("ch0_xfer2_addr", lane(m_kg_addr, 0), 32'h00000000);
      axi_read("ch0_count", 16'h0008, 32'h00020000, OKAY);
      axi_read("ch0_addr_inc", 16'h0000, 32'h00000004, OKAY);

      // Channel 2: a write while busy is dropped.
      axi_write("ch2_data1", 16'h0024, 32'h00000001, 4'hF, OKAY, '0);
      axi_write("ch2_drop", 16'h0024, 32'h00000002, 4'hF, ERR_DROP, '0);
      checkOutput("ch2_still_valid", {31'd0, m_kg_valid[2]}, 32'd1);
      checkOutput("ch2_data_out", lane(m_kg_data, 2), 32'h00000001);
      axi_read("ch2_data_kept", 16'h0024, 32'h00000001, OKAY);
      axi_read("ch2_status_ovf", 16'h0028, 32'h00000001 | OVF_BIT, OKAY);
      axi_write("ch2_w1c", 16'h0028, 32'h00000002, 4'hF, OKAY, '0);
      axi_read("ch2_status_clr", 16'h0028, 32'h00000001, OKAY);

      // Channel 1: DATA write on the completing edge relaunches back-to-back.
      axi_write("b2b_first", 16'h0014, 32'h11111111, 4'hF, OKAY, '0);
      axi_write("b2b_second", 16'h0014, 32'h22222222, 4'hF, OKAY, 4'b0010);
      checkOutput("b2b_valid", {31'd0, m_kg_valid[1]}, 32'd1);
      checkOutput("b2b_data_out", lane(m_kg_data, 1), 32'h22222222);
      axi_read("b2b_status", 16'h0018, 32'h00020001, OKAY);
      pulse_ready(1);
      axi_read("b2b_final", 16'h0018, 32'h00030000, OKAY);

      axi_concurrent("same_reg", 16'h0000, 32'h00000055, OKAY, 16'h0000, 32'h00000004, OKAY);
      axi_read("same_reg_after", 16'h0000, 32'h00000055, OKAY);

      // Flush of busy channel 2 while an unmapped read is in flight.
      axi_concurrent("flush_unmap", 16'h002C, 32'h00000002, OKAY, 16'h0040, 32'h0, ERR_UNMAP);
      checkOutput("flush_valid", {31'd0, m_kg_valid[2]}, 32'd0);
      axi_read("flush_status", 16'h0028, 32'h00000000, OKAY);

      // Asynchronous reset in the middle of a write with channel 1 busy.
      axi_write("pre_rst", 16'h0014, 32'h00000077, 4'hF, OKAY, '0);
      @(posedge clk); #1;
      s_axil_awaddr = 16'h0030; s_axil_wdata = 32'h00000099; s_axil_wstrb = 4'hF;
      s_axil_awvalid = 1'b1; s_axil_wvalid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      checkOutput("rst1_valid", {28'd0, m_kg_valid}, 32'd0);
      checkOutput("rst1_addr_any", {31'd0, |m_kg_addr}, 32'd0);
      checkOutput("rst1_data_any", {31'd0, |m_kg_data}, 32'd0);
      checkOutput("rst1_bvalid", {31'd0, s_axil_bvalid}, 32'd0);
      checkOutput("rst1_awready", {31'd0, s_axil_awready}, 32'd0);
      s_axil_awvalid = 1'b0; s_axil_wvalid = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      for (int c = 0; c < CH; c++)
         axi_read($sformatf("rst1_status%0d", c), 16'(c * 16 + 8), 32'h0, OKAY);
      axi_read("rst1_ch3_addr", 16'h0030, 32'h0, OKAY);
      axi_read("rst1_ch1_data", 16'h0014, 32'h0, OKAY);

      repeat (2) @(negedge clk);
      checkOutput("rd_q_drained", 32'(rd_q.size()), 32'd0);
      checkOutput("wr_q_drained", 32'(wr_q.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
